// File: rtl/zeroriscy_mem_arbiter.sv
// ---------------------------------------------------------------------------
// zeroriscy_mem_arbiter
//
// Shares one single-port memory between the instruction fetch path and the
// load/store unit. The address phase is forwarded combinationally from the
// selected master. Data requests win by default. Fetch is forced through
// after STARVE_LIMIT consecutive data grants while it waits. An in-order
// FIFO of source tags routes each response back to the master that issued
// the request.
//
// Handshake: a master raises req and holds req and its address phase until
// it sees gnt high in the same cycle. The memory accepts an address phase
// when mem_req_o && mem_gnt_i. It answers with mem_rvalid_i at least one
// cycle later, and answers in grant order.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_*                 fetch master: req/addr in, gnt/rvalid/rdata out
//   data_*                  LSU master: req/addr/we/be/wdata in,
//                           gnt/rvalid/rdata out
//   mem_*                   memory side: req/addr/we/be/wdata out,
//                           gnt/rvalid/rdata in
//   busy_o                  address phase pending or response outstanding
// ---------------------------------------------------------------------------
module zeroriscy_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    localparam int                PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]        CNT_MAX    = 3'(MAX_OUTSTANDING);
    localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    // Outstanding-transaction FIFO (one source tag per entry)
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [2:0]                 cnt_q, cnt_d;

    // Address-phase lock and fetch starvation counter
    logic                       lock_valid_q, lock_valid_d;
    src_e                       lock_src_q, lock_src_d;
    logic [3:0]                 starve_q, starve_d;

    logic                       full;
    logic                       locked_req;
    logic                       sel_valid;
    src_e                       sel_src;
    logic                       push;
    logic                       pop;
    src_e                       head_src;

    assign full       = (cnt_q == CNT_MAX);
    assign locked_req = (lock_src_q == SRC_DATA) ? data_req_i : instr_req_i;

    // Source selection. When full, nothing is offered to the memory. A
    // same-cycle rvalid does not change this, so rvalid never reaches req.
    always_comb begin
        sel_valid = 1'b0;
        sel_src   = SRC_INSTR;
        if (!full) begin
            if (lock_valid_q && locked_req) begin
                sel_valid = 1'b1;
                sel_src   = lock_src_q;
            end else if (instr_req_i && (starve_q == STARVE_MAX || !data_req_i)) begin
                sel_valid = 1'b1;
                sel_src   = SRC_INSTR;
            end else if (data_req_i) begin
                sel_valid = 1'b1;
                sel_src   = SRC_DATA;
            end
        end
    end

    // Address-phase forwarding. All fields stay 0 while nothing is selected.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = 32'h0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        if (sel_valid) begin
            mem_req_o = 1'b1;
            if (sel_src == SRC_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
                data_gnt_o  = mem_gnt_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_be_o    = 4'hF;
                instr_gnt_o = mem_gnt_i;
            end
        end
    end

    assign push     = sel_valid && mem_gnt_i;
    // A stray rvalid with nothing outstanding is ignored.
    assign pop      = mem_rvalid_i && (cnt_q != 3'd0);
    assign head_src = src_e'(fifo_q[rptr_q]);

    assign instr_rvalid_o = pop && (head_src == SRC_INSTR);
    assign data_rvalid_o  = pop && (head_src == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign busy_o = mem_req_o || (cnt_q != 3'd0);

    // FIFO next state
    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            fifo_d[wptr_q] = logic'(sel_src);
            wptr_d         = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // The lock holds an ungranted address phase on its master. It drops on
    // grant, or when the locked master withdraws its request. In both cases
    // sel_valid && !mem_gnt_i is false, or a different source was chosen.
    always_comb begin
        lock_valid_d = sel_valid && !mem_gnt_i;
        lock_src_d   = sel_valid ? sel_src : lock_src_q;
    end

    // Consecutive data grants while fetch waits, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) begin
            starve_d = 4'd0;
        end else if (data_gnt_o && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= 3'd0;
            lock_valid_q <= 1'b0;
            lock_src_q   <= SRC_INSTR;
            starve_q     <= 4'd0;
        end else begin
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            lock_valid_q <= lock_valid_d;
            lock_src_q   <= lock_src_d;
            starve_q     <= starve_d;
        end
    end

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zeroriscy_mem_arbiter
//
// Directed scenarios plus a short random single-master phase. Address-phase
// outputs are checked on the falling edge. Inputs change 1 ns after the
// rising edge. Responses go through a scoreboard: when the bench drives
// mem_rvalid_i, it pushes the expected {source, rdata} pair. A monitor pops
// and compares the pair whenever instr_rvalid_o or data_rvalid_o fires.
// ---------------------------------------------------------------------------
module tb_zeroriscy_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // {is_data, rdata}
    logic [32:0] exp_q[$];

    zeroriscy_mem_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (instr_rvalid_o || data_rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_src", {30'd0, data_rvalid_o, instr_rvalid_o}, e[32] ? 32'd2 : 32'd1);
                check("rsp_data", e[32] ? data_rdata_o : instr_rdata_o, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_rsp(input logic is_data, input logic [31:0] rdata);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        exp_q.push_back({is_data, rdata});
    endtask

    task automatic drive_instr(input logic [31:0] addr, input logic gnt);
        instr_req_i  = 1'b1;
        instr_addr_i = addr;
        mem_gnt_i    = gnt;
    endtask

    task automatic drive_data(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input logic gnt);
        data_req_i   = 1'b1;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wdata;
        mem_gnt_i    = gnt;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        exp_d;
        logic        prev_src;
        logic [31:0] rd;

        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
        check("rst_be", {28'd0, mem_be_o}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // ---- fetch only ----
        drive_instr(32'h80, 1'b1);
        sample();
        check("f_mem_req", {31'd0, mem_req_o}, 32'd1);
        check("f_addr", mem_addr_o, 32'h80);
        check("f_be", {28'd0, mem_be_o}, 32'hF);
        check("f_we", {31'd0, mem_we_o}, 32'd0);
        check("f_wdata", mem_wdata_o, 32'd0);
        check("f_igtn", {31'd0, instr_gnt_o}, 32'd1);
        check("f_dgnt", {31'd0, data_gnt_o}, 32'd0);
        next_cycle();
        set_idle();
        drive_rsp(1'b0, 32'h00000013);
        sample();
        check("f_irvalid", {31'd0, instr_rvalid_o}, 32'd1);
        check("f_irdata", instr_rdata_o, 32'h00000013);
        check("f_drvalid", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        set_idle();
        sample();
        check("f_busy_end", {31'd0, busy_o}, 32'd0);
        next_cycle();

        // ---- simultaneous request: data first ----
        drive_instr(32'h100, 1'b1);
        drive_data(32'h2000, 1'b1, 4'h3, 32'hDEADBEEF, 1'b1);
        sample();
        check("s_addr0", mem_addr_o, 32'h2000);
        check("s_we0", {31'd0, mem_we_o}, 32'd1);
        check("s_be0", {28'd0, mem_be_o}, 32'h3);
        check("s_wdata0", mem_wdata_o, 32'hDEADBEEF);
        check("s_gnts0", {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
        next_cycle();
        data_req_i = 1'b0;
        drive_rsp(1'b1, 32'hAAAA0001);
        sample();
        check("s_addr1", mem_addr_o, 32'h100);
        check("s_we1", {31'd0, mem_we_o}, 32'd0);
        check("s_gnts1", {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
        next_cycle();
        set_idle();
        drive_rsp(1'b0, 32'hBBBB0002);
        sample();
        next_cycle();
        set_idle();
        next_cycle();

        // ---- lock holds the ungranted fetch address ----
        drive_instr(32'h40, 1'b0);
        sample();
        check("l_addr0", mem_addr_o, 32'h40);
        next_cycle();
        drive_data(32'h3000, 1'b0, 4'hF, 32'h0, 1'b0);
        for (int c = 1; c < 3; c++) begin
            sample();
            check("l_addr", mem_addr_o, 32'h40);
            check("l_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
            next_cycle();
        end
        mem_gnt_i = 1'b1;
        sample();
        check("l_addr3", mem_addr_o, 32'h40);
        check("l_gnts3", {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
        next_cycle();
        instr_req_i = 1'b0;
        sample();
        check("l_addr4", mem_addr_o, 32'h3000);
        check("l_gnts4", {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
        next_cycle();
        set_idle();
        drive_rsp(1'b0, 32'h11110040);
        next_cycle();
        set_idle();
        drive_rsp(1'b1, 32'h22223000);
        next_cycle();
        set_idle();
        next_cycle();

        // ---- starvation: D,D,D,D,I repeating ----
        prev_src = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_idle();
            drive_instr(32'h200, 1'b1);
            drive_data(32'h4000 + 32'(i * 4), 1'b0, 4'hF, 32'h0, 1'b1);
            if (i > 0) begin
                rd = $urandom();
                drive_rsp(prev_src, rd);
            end
            exp_d = ((i % 5) != 4);
            sample();
            check("st_dgnt", {31'd0, data_gnt_o}, {31'd0, exp_d});
            check("st_ignt", {31'd0, instr_gnt_o}, {31'd0, !exp_d});
            check("st_addr", mem_addr_o, exp_d ? 32'h4000 + 32'(i * 4) : 32'h200);
            prev_src = exp_d;
            next_cycle();
        end
        set_idle();
        rd = $urandom();
        drive_rsp(prev_src, rd);
        next_cycle();
        set_idle();
        next_cycle();

        // ---- full: two outstanding fetches block a third ----
        drive_instr(32'h500, 1'b1);
        sample();
        check("fu_ignt0", {31'd0, instr_gnt_o}, 32'd1);
        next_cycle();
        drive_instr(32'h504, 1'b1);
        sample();
        check("fu_ignt1", {31'd0, instr_gnt_o}, 32'd1);
        next_cycle();
        drive_instr(32'h508, 1'b1);
        sample();
        check("fu_req2", {31'd0, mem_req_o}, 32'd0);
        check("fu_ignt2", {31'd0, instr_gnt_o}, 32'd0);
        check("fu_busy2", {31'd0, busy_o}, 32'd1);
        next_cycle();
        drive_rsp(1'b0, 32'h50050000);
        sample();
        check("fu_req3", {31'd0, mem_req_o}, 32'd0);
        check("fu_ignt3", {31'd0, instr_gnt_o}, 32'd0);
        check("fu_busy3", {31'd0, busy_o}, 32'd1);
        next_cycle();
        drive_rsp(1'b0, 32'h50450000);
        sample();
        check("fu_req4", {31'd0, mem_req_o}, 32'd1);
        check("fu_ignt4", {31'd0, instr_gnt_o}, 32'd1);
        check("fu_addr4", mem_addr_o, 32'h508);
        check("fu_busy4", {31'd0, busy_o}, 32'd1);
        next_cycle();
        set_idle();
        drive_rsp(1'b0, 32'h50850000);
        sample();
        check("fu_busy5", {31'd0, busy_o}, 32'd1);
        next_cycle();
        set_idle();
        sample();
        check("fu_busy6", {31'd0, busy_o}, 32'd0);
        next_cycle();

        // ---- reset drops outstanding entries ----
        drive_instr(32'h600, 1'b1);
        next_cycle();
        drive_instr(32'h604, 1'b1);
        next_cycle();
        set_idle();
        sample();
        check("rs_busy_pre", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_busy_rst", {31'd0, busy_o}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD00001;
        sample();
        check("rs_irvalid", {31'd0, instr_rvalid_o}, 32'd0);
        check("rs_drvalid", {31'd0, data_rvalid_o}, 32'd0);
        check("rs_busy", {31'd0, busy_o}, 32'd0);
        next_cycle();
        sample();
        check("rs_stray_busy", {31'd0, busy_o}, 32'd0);
        next_cycle();
        set_idle();
        // Count must be 0: two fresh fetches accepted, the third blocked.
        drive_instr(32'h700, 1'b1);
        sample();
        check("rs_ignt0", {31'd0, instr_gnt_o}, 32'd1);
        next_cycle();
        sample();
        check("rs_ignt1", {31'd0, instr_gnt_o}, 32'd1);
        next_cycle();
        sample();
        check("rs_full", {31'd0, mem_req_o}, 32'd0);
        next_cycle();
        set_idle();
        drive_rsp(1'b0, 32'h70000000);
        next_cycle();
        set_idle();
        drive_rsp(1'b0, 32'h70000001);
        next_cycle();
        set_idle();
        next_cycle();

        // ---- random single-master transactions ----
        for (int k = 0; k < 16; k++) begin
            logic        src;
            logic [31:0] addr;
            logic [31:0] wd;
            logic        we;
            int          wait_c;
            int          lat;
            src    = 1'($urandom_range(0, 1));
            addr   = {$urandom_range(0, 32'h3FFF), 2'b00};
            wd     = $urandom();
            we     = 1'($urandom_range(0, 1));
            wait_c = $urandom_range(0, 2);
            lat    = $urandom_range(0, 2);
            for (int w = 0; w <= wait_c; w++) begin
                set_idle();
                if (src) drive_data(addr, we, 4'hF, wd, (w == wait_c));
                else     drive_instr(addr, (w == wait_c));
                sample();
                check("r_req", {31'd0, mem_req_o}, 32'd1);
                check("r_addr", mem_addr_o, addr);
                check("r_we", {31'd0, mem_we_o}, src ? {31'd0, we} : 32'd0);
                check("r_gnt", {30'd0, instr_gnt_o, data_gnt_o},
                      (w == wait_c) ? (src ? 32'd1 : 32'd2) : 32'd0);
                next_cycle();
            end
            set_idle();
            for (int l = 0; l < lat; l++) begin
                next_cycle();
            end
            drive_rsp(src, $urandom());
            next_cycle();
            set_idle();
        end
        next_cycle();

        check("rsp_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
